// File: rtl/cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// cdc_hs_tx
// Source half of a toggle request/acknowledge clock-domain crossing for
// multi-bit words. A word is taken through a valid/ready handshake, held on
// data_out, and announced by toggling req_out. The next word is only taken once
// the receiver's acknowledge toggle (synchronised through two flops) matches
// the request phase again.
//
// Optional feature: define CDC_HS_TX_TIMEOUT_EN to add an acknowledge timeout.
// On expiry the block parks in ERROR with timeout_err set until rst_n.
//
// Parameters:
//   WIDTH           transferred word width
//   TIMEOUT_CYCLES  acknowledge timeout in clk cycles (timeout build only, >= 4)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     producer has a word
//   in_data      word to transfer
//   in_ready     block can accept a word (state == IDLE, not gated by inputs)
//   data_out     held word, routed to the receiver domain
//   req_out      request toggle
//   ack_in       acknowledge toggle from the receiver domain (asynchronous)
//   busy         1 while a transfer is outstanding
//   timeout_err  sticky acknowledge-timeout flag (0 unless timeout built in)
// -----------------------------------------------------------------------------
module cdc_hs_tx #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             req_out,
   input  logic             ack_in,
   output logic             busy,
   output logic             timeout_err
);

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, ERROR = 2'd2} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;
`endif

   state_t           state, nxt_state;
   logic [WIDTH-1:0] nxt_data;
   logic             nxt_req;
   logic             nxt_busy;
   logic             ack_s1, ack_s2;

`ifdef CDC_HS_TX_TIMEOUT_EN
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic             err_q, nxt_err;
`endif

   // Two-flop synchroniser; only ack_s2 is used by the control logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= ack_in;
         ack_s2 <= ack_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         data_out <= '0;
         req_out  <= 1'b0;
         busy     <= 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
         cnt      <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state    <= nxt_state;
         data_out <= nxt_data;
         req_out  <= nxt_req;
         busy     <= nxt_busy;
`ifdef CDC_HS_TX_TIMEOUT_EN
         cnt      <= nxt_cnt;
         err_q    <= nxt_err;
`endif
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_data  = data_out;
      nxt_req   = req_out;
      nxt_busy  = busy;
`ifdef CDC_HS_TX_TIMEOUT_EN
      nxt_cnt   = cnt;
      nxt_err   = err_q;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               nxt_state = WAIT_ACK;
               nxt_data  = in_data;
               nxt_req   = ~req_out;
               nxt_busy  = 1'b1;
`ifdef CDC_HS_TX_TIMEOUT_EN
               nxt_cnt   = '0;
`endif
            end
         end
         WAIT_ACK: begin
            // Acknowledge is checked first so it wins over a coincident
            // terminal count.
            if (ack_s2 == req_out) begin
               nxt_state = IDLE;
               nxt_busy  = 1'b0;
            end
`ifdef CDC_HS_TX_TIMEOUT_EN
            // Terminal edge is the one on which the counter would reach
            // TIMEOUT_CYCLES, so the flag rises TIMEOUT_CYCLES edges after accept.
            else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               nxt_state = ERROR;
               nxt_err   = 1'b1;
            end else begin
               nxt_cnt   = cnt + 1'b1;
            end
`endif
         end
`ifdef CDC_HS_TX_TIMEOUT_EN
         ERROR: ;  // left only through rst_n; busy stays high
`endif
         default: ;
      endcase
   end

   assign in_ready = (state == IDLE);

`ifdef CDC_HS_TX_TIMEOUT_EN
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx. A reference model driven from the
// observable protocol rules (an ack seen on ack_in at edge k is acted on at
// edge k+2) predicts all outputs every cycle.
module tb_cdc_hs_tx;
   localparam int W  = 32;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         ack_in = 1'b0;
   logic         in_ready, req_out, busy, timeout_err;
   logic [W-1:0] data_out;

   cdc_hs_tx #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .data_out(data_out), .req_out(req_out),
      .ack_in(ack_in), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc = 0;

   // Reference model
   logic         m_ready, m_req, m_busy, m_err;
   logic [W-1:0] m_data;
   logic         a_p1, a_p2;   // ack_in seen at edges k-1 and k-2
   int           acc_cyc;

   // Receiver: 0 = ack held, 1 = immediate loop-back, 2 = one-cycle delayed,
   // 3 = random latency loop-back
   int   lb_mode = 0;
   logic lb_prev = 1'b0;

   task automatic model_reset();
      m_ready = 1'b1; m_req = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      m_data = '0; a_p1 = 1'b0; a_p2 = 1'b0; acc_cyc = 0;
   endtask

   task automatic tick();
      logic a_use;
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else begin
         a_use = a_p2;
         a_p2 = a_p1;
         a_p1 = ack_in;
         if (m_ready) begin
            if (in_valid) begin
               m_data = in_data; m_req = ~m_req; m_ready = 1'b0;
               m_busy = 1'b1; acc_cyc = cyc;
            end
         end else if (!m_err) begin
            if (a_use == m_req) begin
               m_ready = 1'b1; m_busy = 1'b0;
            end
`ifdef CDC_HS_TX_TIMEOUT_EN
            else if (cyc - acc_cyc == TO) m_err = 1'b1;
`endif
         end
      end
      #1;
      if (!rst_n) lb_prev = 1'b0;
      else if (lb_mode == 1) ack_in = req_out;
      else if (lb_mode == 2) ack_in = lb_prev;
      else if (lb_mode == 3 && $urandom_range(1, 0) == 1) ack_in = req_out;
      lb_prev = req_out;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; lb_mode = 0; ack_in = 1'b0;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({in_ready, req_out, busy, timeout_err, data_out} !== {4'b1000, {W{1'b0}}}) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got rdy=%b req=%b busy=%b err=%b data=%h want 1 0 0 0 0",
                     i, in_ready, req_out, busy, timeout_err, data_out);
         end
      end
   endtask

   task automatic test_single();
      int n;
      do_reset();
      lb_mode = 2;
      in_data = 32'hDEADBEEF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({req_out, in_ready, data_out} !== {2'b10, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL single_accept got req=%b rdy=%b data=%h want 1 0 deadbeef",
                  req_out, in_ready, data_out);
      end
      n = 0;
      for (int c = 0; c < 12 && !in_ready; c++) begin tick(); n++; end
      // ack_in moves after edge N+1, so ready returns at edge N+4
      checks++;
      if (n != 4 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_latency got %0d edges rdy=%b want 4 edges rdy=1", n, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] words[8];
      logic prev_req;
      int n_acc;
      do_reset();
      foreach (words[i]) words[i] = $urandom;
      lb_mode = 1;
      n_acc = 0;
      in_data = words[0]; in_valid = 1'b1;
      for (int c = 0; c < 100 && n_acc < 8; c++) begin
         prev_req = req_out;
         tick();
         checks++;
         if ({in_ready, req_out, busy, timeout_err, data_out} !== {m_ready, m_req, m_busy, m_err, m_data}) begin
            failures++;
            $display("FAIL b2b_model cyc=%0d got %b%b%b%b %h want %b%b%b%b %h", c,
                     in_ready, req_out, busy, timeout_err, data_out, m_ready, m_req, m_busy, m_err, m_data);
         end
         if (req_out !== prev_req) begin
            checks++;
            if (data_out !== words[n_acc]) begin
               failures++;
               $display("FAIL b2b_order word=%0d got %h want %h", n_acc, data_out, words[n_acc]);
            end
            n_acc++;
            if (n_acc < 8) in_data = words[n_acc]; else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n_acc != 8 || req_out !== 1'b0) begin
         failures++;
         $display("FAIL b2b_count got %0d toggles req=%b want 8 toggles req=0", n_acc, req_out);
      end
      for (int c = 0; c < 20 && !in_ready; c++) tick();
   endtask

   task automatic test_data_stability();
      logic [W-1:0] w;
      lb_mode = 0;
      w = $urandom;
      in_data = w; in_valid = 1'b1;
      tick();
      in_valid = 1'b1;   // still asserted: must not be taken while waiting
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom;
         tick();
         checks++;
         if (data_out !== w || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stability cyc=%0d got data=%h rdy=%b busy=%b want %h 0 1",
                     i, data_out, in_ready, busy, w);
         end
      end
      in_valid = 1'b0;
      lb_mode = 1;
      for (int c = 0; c < 20 && !in_ready; c++) tick();
      checks++;
      if (in_ready !== 1'b1 || data_out !== w) begin
         failures++;
         $display("FAIL stability_drain got rdy=%b data=%h want 1 %h", in_ready, data_out, w);
      end
   endtask

   task automatic test_random();
      do_reset();
      lb_mode = 3;
      for (int c = 0; c < 300; c++) begin
         in_valid = ($urandom_range(3, 0) != 0);
         in_data = $urandom;
         tick();
         checks++;
         if ({in_ready, req_out, busy, timeout_err, data_out} !== {m_ready, m_req, m_busy, m_err, m_data}) begin
            failures++;
            $display("FAIL random_model cyc=%0d got %b%b%b%b %h want %b%b%b%b %h", c,
                     in_ready, req_out, busy, timeout_err, data_out, m_ready, m_req, m_busy, m_err, m_data);
         end
      end
      in_valid = 1'b0;
      lb_mode = 1;
      for (int c = 0; c < 20 && !in_ready; c++) tick();
   endtask

   task automatic test_reset_mid();
      lb_mode = 0;
      in_data = $urandom; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, req_out, busy, timeout_err, data_out} !== {4'b1000, {W{1'b0}}}) begin
         failures++;
         $display("FAIL reset_mid got rdy=%b req=%b busy=%b err=%b data=%h want 1 0 0 0 0",
                  in_ready, req_out, busy, timeout_err, data_out);
      end
      ack_in = 1'b0;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      lb_mode = 1;
      in_data = 32'hA5A55A5A; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (req_out !== 1'b1 || data_out !== 32'hA5A55A5A || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_retx got req=%b data=%h rdy=%b want 1 a5a55a5a 0",
                  req_out, data_out, in_ready);
      end
      for (int c = 0; c < 20 && !in_ready; c++) tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_done got rdy=%b busy=%b want 1 0", in_ready, busy);
      end
   endtask

`ifdef CDC_HS_TX_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      in_data = $urandom; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         tick();
         checks++;
         if (timeout_err !== (i == TO) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL timeout_edge i=%0d got err=%b rdy=%b want %b 0", i, timeout_err, in_ready, i == TO);
         end
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         tick();
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_stuck got rdy=%b busy=%b err=%b want 0 1 1", in_ready, busy, timeout_err);
         end
      end
      // Ack timed so its match lands on the terminal-count edge.
      do_reset();
      in_data = $urandom; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         tick();
         if (i == 13) ack_in = 1'b1;
      end
      checks++;
      if (in_ready !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_ack_wins got rdy=%b err=%b busy=%b want 1 0 0", in_ready, timeout_err, busy);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_data_stability();
      test_random();
      test_reset_mid();
`ifdef CDC_HS_TX_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source-side half of a four-phase-free (toggle) request/acknowledge clock-domain crossing for multi-bit words. It accepts a word through a valid/ready handshake, holds it stable on `data_out`, and signals it with a toggle on `req_out`. It then waits until the receiver's toggle acknowledge, synchronised internally through two flops, matches the request phase before accepting the next word. It sits in the producer clock domain, for example at DSI controller register/command paths that feed the byte-clock domain, and pairs with a receiver built from the team's 2-FF synchroniser.

## Interface
Parameters:
- `WIDTH`, 32: width of the transferred word.
- `TIMEOUT_CYCLES`, 1023: acknowledge timeout in `clk` cycles. Used only when `CDC_HS_TX_TIMEOUT_EN` is defined. Must be at least 4.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  WIDTH  word to transfer.
- `in_ready`  out  1  block can accept a word; equals (state == IDLE) and is not gated by inputs.
- `data_out`  out  WIDTH  registered held word, routed to the other domain.
- `req_out`  out  1  registered request toggle.
- `ack_in`  in  1  acknowledge toggle from the receiver domain; asynchronous to `clk`.
- `busy`  out  1  registered; 1 while in WAIT_ACK.
- `timeout_err`  out  1  sticky acknowledge-timeout flag.

## Operation
- `ack_in` passes through two flops, `ack_s1` → `ack_s2`. No logic uses `ack_in` or `ack_s1` directly.
- States:
  - IDLE: `in_ready` = 1.
  - WAIT_ACK: `in_ready` = 0.
  - ERROR: `in_ready` = 0. Only reachable when timeout is compiled in.
- IDLE, on `in_valid && in_ready`:
  - `data_out` ← `in_data`.
  - `req_out` ← ~`req_out`.
  - `busy` ← 1.
  - Go to WAIT_ACK.
- IDLE with `in_valid` = 0: all outputs hold.
- WAIT_ACK, when `ack_s2 == req_out`: go to IDLE and `busy` ← 0. `data_out` and `req_out` stay unchanged.
- WAIT_ACK otherwise: remain in WAIT_ACK.
- `data_out` changes only on an accept. It is never modified in WAIT_ACK, so the receiver may sample it once it sees the synchronised request toggle.
- Transfers alternate the `req_out` phase 0→1→0→…. A receiver acknowledges by copying the synchronised request phase onto `ack_in`.
- A spurious `ack_in` toggle while in IDLE has no effect until the next accept. If it leaves `ack_s2 == ~req_out` at accept time, that transfer completes immediately. This is a receiver protocol violation and the block does not detect it.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1.
  - `req_out` = 0, `data_out` = 0, `busy` = 0, `timeout_err` = 0.
  - `ack_s1` = 0, `ack_s2` = 0.
- Accept happens at edge N. `req_out`, `data_out` and `busy` update at N; `in_ready` drops at N.
- `ack_in` changes between edges M-1 and M:
  - `ack_s1` updates at M.
  - `ack_s2` updates at M+1.
  - State returns to IDLE at M+2, and `in_ready` = 1 from M+2.
  - The next accept is possible at M+3.
- Minimum round trip through a zero-latency loop-back receiver: 4 cycles per word.
- Reset asserted mid-transfer: all registers return to reset values immediately and asynchronously. The receiver must be reset in the same event, since the request phase restarts at 0.

## Configuration
- `CDC_HS_TX_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on accept and increments each cycle in WAIT_ACK.
  - If the counter reaches `TIMEOUT_CYCLES` before acknowledge, the block goes to ERROR and sets `timeout_err` ← 1. `busy` stays 1.
  - ERROR is left only by `rst_n`.
  - If the acknowledge match and the terminal count occur in the same cycle, the acknowledge wins and the block goes to IDLE.
- `CDC_HS_TX_TIMEOUT_EN` undefined:
  - No counter and no ERROR state.
  - `timeout_err` is tied to 0.
  - WAIT_ACK waits indefinitely.

## Test plan
- Reset then idle: release `rst_n` → `in_ready`=1, `req_out`=0, `data_out`=0, `busy`=0, `timeout_err`=0, held for 20 cycles with `in_valid`=0.
- Single transfer with `in_data`=32'hDEADBEEF, loop-back `ack_in`=`req_out` delayed 1 cycle:
  - Next edge: `req_out`=1, `data_out`=DEADBEEF, `in_ready`=0.
  - `in_ready` returns 3 cycles after the `ack_in` change.
- Back-to-back: 8 words with `in_valid` held high and a loop-back receiver:
  - `req_out` toggles 8 times, ending at 0.
  - Each word appears on `data_out` in order.
  - No word is accepted while `busy`=1.
- Data stability: change `in_data` every cycle while in WAIT_ACK → `data_out` does not change until the next accept.
- Timeout, with macro and `TIMEOUT_CYCLES`=16, `ack_in` stuck at 0:
  - `timeout_err`=1 exactly 16 cycles after accept.
  - `in_ready` stays 0 until reset.
  - An ack arriving in the same cycle as the terminal count returns the block to IDLE with no error.
- Reset mid-transfer: assert `rst_n` low in WAIT_ACK → outputs return to reset values within the same cycle, and a subsequent transfer works with `req_out` going 0→1.
